slow_tick_timekeeper: RTL and testbench

Consumes the slow toggling divider clock (`clk_1sec`) as a plain data signal in the 50 MHz `clk` domain. Every toggle of that signal becomes a one-cycle `tick` pulse. The ticks drive a run-controlled BCD MM:SS timekeeper for the display path. A watchdog flags missing or early toggles so a stalled or misconfigured divider is visible to the system.

---
 rtl/tk_pkg.sv | 37 +++
 rtl/tick_sync.sv | 30 +++
 rtl/slow_tick_timekeeper.sv | 130 +++++++++++++
 tb/tb_slow_tick_timekeeper.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tk_pkg.sv
// Shared types and constants for the slow-tick timekeeper.
package tk_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    LOST    = 2'd2
  } wd_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_UNITS = 4'd9;
  localparam bcd_t BCD_MAX_TENS  = 4'd5;

  // Result of advancing one BCD digit: new digit plus carry into the next.
  typedef struct packed {
    bcd_t digit;
    logic carry;
  } bcd_step_t;

  // Advance a digit by one when en is set, wrapping to 0 past max_val.
  function automatic bcd_step_t bcd_inc(input bcd_t d, input bcd_t max_val, input logic en);
    bcd_step_t r;
    r.digit = d;
    r.carry = 1'b0;
    if (en) begin
      if (d == max_val) begin
        r.digit = '0;
        r.carry = 1'b1;
      end else begin
        r.digit = d + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizes a slow toggling level into clk and emits a registered
// one-cycle pulse for every level change, rising or falling.
module tick_sync #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the input through the synchronizer, keep one history bit, register the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real flops do.
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      tick   <= sync_q[SYNC_STAGES-1] ^ hist_q;
    end
  end

endmodule

// File: rtl/slow_tick_timekeeper.sv
// Turns toggles of a slow divider clock into ticks, counts them into a
// run-controlled BCD MM:SS display time and watches the toggle spacing.
module slow_tick_timekeeper
  import tk_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int TICK_CYCLES   = 10_000_000,
  parameter int TOL_CYCLES    = 1_000_000,
  parameter int TICKS_PER_SEC = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_1sec,
  input  logic start,
  input  logic stop,
  input  logic clear,
  output logic tick,
  output logic running,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic rollover,
  output logic tick_lost
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  localparam int GAP_W = $clog2(TICK_CYCLES + TOL_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TICK_CYCLES + TOL_CYCLES);
  localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(TICK_CYCLES - TOL_CYCLES);

  logic [PRE_W-1:0] prescaler;
  logic [GAP_W-1:0] gap_cnt;
  wd_state_t        wd_state;

  logic      presc_adv;
  logic      sec_inc;
  bcd_step_t sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(clk_1sec),
    .tick    (tick)
  );

  // Run flag: stop beats a coincident start; clear leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     running <= 1'b0;
    else if (stop)  running <= 1'b0;
    else if (start) running <= 1'b1;
  end

  // Ripple the seconds increment through the four BCD digits.
  always_comb begin
    // NOTE: every always_comb output is given a value on every path
    // (here via the helper's defaults) so no latch is inferred.
    presc_adv  = tick & running;
    sec_inc    = presc_adv & (prescaler == PRE_LAST);
    sec_ones_s = bcd_inc(sec_ones, BCD_MAX_UNITS, sec_inc);
    sec_tens_s = bcd_inc(sec_tens, BCD_MAX_TENS,  sec_ones_s.carry);
    min_ones_s = bcd_inc(min_ones, BCD_MAX_UNITS, sec_tens_s.carry);
    min_tens_s = bcd_inc(min_tens, BCD_MAX_TENS,  min_ones_s.carry);
  end

  // Prescaler, display digits and the registered rollover pulse; clear drops a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      sec_ones  <= '0;
      sec_tens  <= '0;
      min_ones  <= '0;
      min_tens  <= '0;
      rollover  <= 1'b0;
    end else if (clear) begin
      prescaler <= '0;
      sec_ones  <= '0;
      sec_tens  <= '0;
      min_ones  <= '0;
      min_tens  <= '0;
      rollover  <= 1'b0;
    end else begin
      if (presc_adv) prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      sec_ones <= sec_ones_s.digit;
      sec_tens <= sec_tens_s.digit;
      min_ones <= min_ones_s.digit;
      min_tens <= min_tens_s.digit;
      rollover <= min_tens_s.carry;
    end
  end

  // Watchdog: lock on the first tick, then flag early or missing toggles until clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_state  <= ACQUIRE;
      gap_cnt   <= '0;
      tick_lost <= 1'b0;
    end else if (clear) begin
      wd_state  <= ACQUIRE;
      gap_cnt   <= '0;
      tick_lost <= 1'b0;
    end else begin
      if (tick)                    gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;

      case (wd_state)
        ACQUIRE: begin
          if (tick) wd_state <= LOCKED;
        end
        LOCKED: begin
          if ((tick && (gap_cnt < GAP_MIN)) || (!tick && (gap_cnt == GAP_MAX))) begin
            wd_state  <= LOST;
            tick_lost <= 1'b1;
          end
        end
        LOST: begin
          tick_lost <= 1'b1;
        end
        default: begin
          wd_state <= ACQUIRE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_tick_timekeeper.sv
// Bench for slow_tick_timekeeper: tick and rollover timing go through a
// scoreboard of expected cycles; counters and flags are compared to constants.
module tb_slow_tick_timekeeper;

  logic       clk;
  logic       rst_n;
  logic       clk_1sec;
  logic       start;
  logic       stop;
  logic       clear;
  logic       tick;
  logic       running;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       rollover;
  logic       tick_lost;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int roll_cnt = 0;
  bit mon_en   = 1'b0;

  int exp_tick[$];
  int exp_roll[$];

  slow_tick_timekeeper #(
    .SYNC_STAGES  (2),
    .TICK_CYCLES  (20),
    .TOL_CYCLES   (4),
    .TICKS_PER_SEC(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_1sec (clk_1sec),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .tick     (tick),
    .running  (running),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .rollover (rollover),
    .tick_lost(tick_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Toggle the slow clock; its tick is due three counted edges later.
  task automatic toggle();
    clk_1sec = ~clk_1sec;
    exp_tick.push_back(cyc + 3);
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s;
    stop  = p;
    clear = c;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  // Scoreboard: every tick and rollover pulse must match the expected cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tick) begin
        if (exp_tick.size() == 0) check("tick_unexpected", tick, 0);
        else                      check("tick_cycle", cyc, exp_tick.pop_front());
      end else if (exp_tick.size() > 0 && exp_tick[0] < cyc) begin
        check("tick_missing", cyc, exp_tick.pop_front());
      end
      if (rollover) begin
        roll_cnt++;
        if (exp_roll.size() == 0) check("rollover_unexpected", rollover, 0);
        else                      check("rollover_cycle", cyc, exp_roll.pop_front());
      end else if (exp_roll.size() > 0 && exp_roll[0] < cyc) begin
        check("rollover_missing", cyc, exp_roll.pop_front());
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    clk_1sec = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    clear    = 1'b0;
    step(3);

    // Reset state
    check("rst_tick", tick, 0);
    check("rst_running", running, 0);
    check("rst_sec_ones", sec_ones, 0);
    check("rst_sec_tens", sec_tens, 0);
    check("rst_min_ones", min_ones, 0);
    check("rst_min_tens", min_tens, 0);
    check("rst_rollover", rollover, 0);
    check("rst_tick_lost", tick_lost, 0);
    rst_n = 1'b1;
    step(2);
    mon_en = 1'b1;

    // Tick latency while stopped
    repeat (4) begin toggle(); step(20); end
    check("lat_sec_ones", sec_ones, 0);
    check("lat_min_ones", min_ones, 0);
    check("lat_running", running, 0);
    check("lat_tick_lost", tick_lost, 0);
    check("lat_queue_empty", exp_tick.size(), 0);

    // Seconds count: 25 ticks at 5 per second
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    repeat (25) begin toggle(); step(20); end
    check("cnt_sec_ones", sec_ones, 5);
    check("cnt_sec_tens", sec_tens, 0);
    check("cnt_min_ones", min_ones, 0);
    check("cnt_prescaler", dut.prescaler, 0);
    check("cnt_running", running, 1);
    check("cnt_tick_lost", tick_lost, 0);

    // Early edge: two toggles 10 cycles apart while locked
    toggle(); step(10);
    toggle(); step(10);
    check("early_tick_lost", tick_lost, 1);
    check("early_sec_ones", sec_ones, 5);
    check("early_prescaler", dut.prescaler, 2);
    repeat (3) begin toggle(); step(20); end
    check("early_keeps_count", sec_ones, 6);
    check("early_sticky", tick_lost, 1);

    // Missing edge: lock, then hold the slow clock
    pulse(0, 0, 1);
    check("clr_tick_lost", tick_lost, 0);
    check("clr_sec_ones", sec_ones, 0);
    toggle(); step(20);
    toggle(); step(20);
    check("miss_not_yet", tick_lost, 0);
    step(15);
    check("miss_tick_lost", tick_lost, 1);
    repeat (2) begin toggle(); step(20); end
    check("miss_sticky", tick_lost, 1);
    pulse(0, 0, 1);
    check("miss_cleared", tick_lost, 0);

    // Priority: stop beats start; clear beats a coincident tick
    pulse(1, 1, 0);
    check("prio_stop_wins", running, 0);
    pulse(1, 0, 0);
    check("prio_start", running, 1);
    repeat (5) begin toggle(); step(20); end
    check("prio_pre_sec", sec_ones, 1);
    toggle(); step(3);
    pulse(0, 0, 1);
    check("prio_clr_sec", sec_ones, 0);
    check("prio_clr_prescaler", dut.prescaler, 0);
    step(16);
    toggle(); step(20);
    check("prio_after_clr_prescaler", dut.prescaler, 1);

    // Rollover: 3599 s plus 4 ticks reach 59:59, one more wraps
    pulse(0, 0, 1);
    repeat (17999) begin toggle(); step(2); end
    step(4);
    check("roll_sec_ones", sec_ones, 9);
    check("roll_sec_tens", sec_tens, 5);
    check("roll_min_ones", min_ones, 9);
    check("roll_min_tens", min_tens, 5);
    check("roll_prescaler", dut.prescaler, 4);
    check("roll_none_yet", roll_cnt, 0);
    toggle();
    exp_roll.push_back(cyc + 4);
    step(4);
    check("roll_pulse", rollover, 1);
    check("roll_wrap_sec", sec_ones, 0);
    check("roll_wrap_min", min_tens, 0);
    step(1);
    check("roll_one_cycle", rollover, 0);
    check("roll_count", roll_cnt, 1);
    check("roll_queue_empty", exp_roll.size(), 0);

    // Asynchronous reset mid-run
    repeat (5) begin toggle(); step(2); end
    step(4);
    check("pre_rst_sec", sec_ones, 1);
    check("pre_rst_tick_lost", tick_lost, 1);
    check("pre_rst_queue_empty", exp_tick.size(), 0);
    mon_en = 1'b0;
    exp_tick.delete();
    #3 rst_n = 1'b0;
    #2;
    check("arst_tick", tick, 0);
    check("arst_running", running, 0);
    check("arst_sec_ones", sec_ones, 0);
    check("arst_sec_tens", sec_tens, 0);
    check("arst_min_ones", min_ones, 0);
    check("arst_min_tens", min_tens, 0);
    check("arst_rollover", rollover, 0);
    check("arst_tick_lost", tick_lost, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
